// File: rtl/parity_pkg.sv
// Shared encodings for the framed serial parity transmitter.
package parity_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam bit EVEN = 1'b0;
    localparam bit ODD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SHIFT  = ST_SHIFT,
        PARITY = ST_PARITY
    } state_e;

endpackage

// File: rtl/parity_accum.sv
// Serial parity datapath: a 1-bit toggle register that XORs in one bit per enabled cycle.
module parity_accum (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_load_val,
    input  logic i_en,
    input  logic i_bit,
    output logic o_q
);

    logic q_q;

    // Load seeds the parity mode; enable folds the next serial bit in.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_q <= 1'b0;
        end else if (i_load) begin
            q_q <= i_load_val;
        end else if (i_en) begin
            q_q <= q_q ^ i_bit;
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/parity_frame_controller.sv
// Framed serial transmitter: accepts a word, shifts it out LSB-first, then appends parity.
module parity_frame_controller
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_ser,
    output logic              o_ser_valid,
    output logic              o_is_parity,
    output logic              o_busy,
    output logic              o_done
);

    // One extra bit so the counter reaches DATA_W without wrapping.
    localparam int unsigned CNT_W    = $clog2(DATA_W) + 1;
    localparam bit          PAR_SEED = (ODD_PARITY != 0) ? ODD : EVEN;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                acc_load, acc_en, acc_q;

    // State, shift register and bit counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and accumulator control.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        acc_load = 1'b0;
        acc_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    shreg_d  = i_data;
                    cnt_d    = '0;
                    acc_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                acc_en  = 1'b1;
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = PARITY;
                end
            end
            PARITY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    parity_accum u_accum (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (acc_load),
        .i_load_val (PAR_SEED),
        .i_en       (acc_en),
        .i_bit      (shreg_q[0]),
        .o_q        (acc_q)
    );

    // Outputs decoded purely from registered state.
    always_comb begin
        o_ready     = 1'b0;
        o_ser       = 1'b0;
        o_ser_valid = 1'b0;
        o_is_parity = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
            end
            SHIFT: begin
                o_ser       = shreg_q[0];
                o_ser_valid = 1'b1;
                o_busy      = 1'b1;
            end
            PARITY: begin
                o_ser       = acc_q;
                o_ser_valid = 1'b1;
                o_is_parity = 1'b1;
                o_done      = 1'b1;
                o_busy      = 1'b1;
            end
            default: begin
                o_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_parity_frame_controller.sv
// Directed bench for parity_frame_controller: even/8, odd/8 and even/1 builds.
module tb_parity_frame_controller;

    logic clk;
    logic rst;

    logic [7:0] e_data;
    logic       e_valid, e_ready, e_ser, e_ser_valid, e_is_par, e_busy, e_done;
    logic [7:0] o_data;
    logic       o_valid, o_ready, o_ser, o_ser_valid, o_is_par, o_busy, o_done;
    logic [0:0] w_data;
    logic       w_valid, w_ready, w_ser, w_ser_valid, w_is_par, w_busy, w_done;

    int checks = 0;
    int errors = 0;

    parity_frame_controller #(.DATA_W(8), .ODD_PARITY(0)) u_even (
        .i_clk(clk), .i_rst(rst), .i_data(e_data), .i_valid(e_valid),
        .o_ready(e_ready), .o_ser(e_ser), .o_ser_valid(e_ser_valid),
        .o_is_parity(e_is_par), .o_busy(e_busy), .o_done(e_done)
    );

    parity_frame_controller #(.DATA_W(8), .ODD_PARITY(1)) u_odd (
        .i_clk(clk), .i_rst(rst), .i_data(o_data), .i_valid(o_valid),
        .o_ready(o_ready), .o_ser(o_ser), .o_ser_valid(o_ser_valid),
        .o_is_parity(o_is_par), .o_busy(o_busy), .o_done(o_done)
    );

    parity_frame_controller #(.DATA_W(1), .ODD_PARITY(0)) u_w1 (
        .i_clk(clk), .i_rst(rst), .i_data(w_data), .i_valid(w_valid),
        .o_ready(w_ready), .o_ser(w_ser), .o_ser_valid(w_ser_valid),
        .o_is_parity(w_is_par), .o_busy(w_busy), .o_done(w_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Even/8 DUT outputs packed as {ready, ser, ser_valid, is_parity, busy, done}.
    function automatic logic [5:0] e_out();
        return {e_ready, e_ser, e_ser_valid, e_is_par, e_busy, e_done};
    endfunction

    // Drives one frame into the even DUT and checks every bit plus the trailing idle.
    task automatic run_even_frame(input logic [7:0] data, input logic par, input string name);
        e_valid = 1'b1;
        e_data  = data;
        checks++;
        if (e_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept got %b want 1", name, e_ready);
        end
        step();
        e_valid = 1'b0;
        e_data  = ~data;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (e_out() !== {1'b0, data[i], 4'b1010}) begin
                errors++;
                $display("FAIL %s data_bit%0d got %b want %b", name, i, e_out(), {1'b0, data[i], 4'b1010});
            end
            step();
        end
        checks++;
        if (e_out() !== {1'b0, par, 4'b1111}) begin
            errors++;
            $display("FAIL %s parity_cycle got %b want %b", name, e_out(), {1'b0, par, 4'b1111});
        end
        step();
        checks++;
        if (e_out() !== 6'b100000) begin
            errors++;
            $display("FAIL %s idle_after got %b want 100000", name, e_out());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        e_valid = 1'b0; e_data = 8'h00;
        o_valid = 1'b0; o_data = 8'h00;
        w_valid = 1'b0; w_data = 1'b0;
        step();
        step();
        checks++;
        if (e_out() !== 6'b100000) begin
            errors++;
            $display("FAIL reset_even got %b want 100000", e_out());
        end
        checks++;
        if ({o_ready, o_ser, o_ser_valid, o_is_par, o_busy, o_done} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_odd got %b want 100000",
                     {o_ready, o_ser, o_ser_valid, o_is_par, o_busy, o_done});
        end
        checks++;
        if ({w_ready, w_ser, w_ser_valid, w_is_par, w_busy, w_done} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_w1 got %b want 100000",
                     {w_ready, w_ser, w_ser_valid, w_is_par, w_busy, w_done});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_even_frames();
        run_even_frame(8'hA5, 1'b0, "even_A5");
        run_even_frame(8'h07, 1'b1, "even_07");
    endtask

    task automatic test_odd_zero();
        o_valid = 1'b1;
        o_data  = 8'h00;
        step();
        o_valid = 1'b0;
        o_data  = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({o_ser, o_ser_valid, o_is_par} !== 3'b010) begin
                errors++;
                $display("FAIL odd_00 bit%0d got %b want 010", i, {o_ser, o_ser_valid, o_is_par});
            end
            step();
        end
        checks++;
        if ({o_ser, o_is_par, o_done} !== 3'b111) begin
            errors++;
            $display("FAIL odd_00 parity got %b want 111", {o_ser, o_is_par, o_done});
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w2;
        w2 = 8'hFF;
        e_valid = 1'b1;
        e_data  = 8'h01;
        step();
        for (int c = 1; c <= 9; c++) begin
            e_data = (c == 9) ? w2 : 8'h5A;
            checks++;
            if (e_ready !== 1'b0) begin
                errors++;
                $display("FAIL b2b ready_low cycle%0d got %b want 0", c, e_ready);
            end
            if (c == 9) begin
                checks++;
                if ({e_ser, e_is_par} !== 2'b11) begin
                    errors++;
                    $display("FAIL b2b parity1 got %b want 11", {e_ser, e_is_par});
                end
            end else begin
                checks++;
                if (e_ser !== (c == 1)) begin
                    errors++;
                    $display("FAIL b2b w1_bit%0d got %b want %b", c - 1, e_ser, (c == 1));
                end
            end
            step();
        end
        checks++;
        if ({e_ready, e_ser_valid} !== 2'b10) begin
            errors++;
            $display("FAIL b2b idle_gap got %b want 10", {e_ready, e_ser_valid});
        end
        step();
        e_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({e_ser, e_ser_valid, e_is_par} !== 3'b110) begin
                errors++;
                $display("FAIL b2b w2_bit%0d got %b want 110", i, {e_ser, e_ser_valid, e_is_par});
            end
            if (i == 0) e_valid = 1'b0;
            step();
        end
        checks++;
        if ({e_ser, e_is_par, e_done} !== 3'b011) begin
            errors++;
            $display("FAIL b2b parity2 got %b want 011", {e_ser, e_is_par, e_done});
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        e_valid = 1'b1;
        e_data  = 8'hFF;
        step();
        e_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({e_ser, e_ser_valid} !== 2'b11) begin
            errors++;
            $display("FAIL midrst bit3 got %b want 11", {e_ser, e_ser_valid});
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (e_out() !== 6'b100000) begin
            errors++;
            $display("FAIL midrst after_reset got %b want 100000", e_out());
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (e_done !== 1'b0 || e_ser_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrst stray_cycle%0d done=%b ser_valid=%b want 0 0", c, e_done, e_ser_valid);
            end
            step();
        end
        run_even_frame(8'h03, 1'b0, "midrst_03");
    endtask

    task automatic test_reset_and_valid();
        rst     = 1'b1;
        e_valid = 1'b1;
        e_data  = 8'h81;
        step();
        rst = 1'b0;
        checks++;
        if ({e_ready, e_ser_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rstvalid no_accept got %b want 10", {e_ready, e_ser_valid});
        end
        step();
        e_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({e_ser, e_ser_valid} !== {(i == 0 || i == 7), 1'b1}) begin
                errors++;
                $display("FAIL rstvalid bit%0d got %b want %b", i, {e_ser, e_ser_valid},
                         {(i == 0 || i == 7), 1'b1});
            end
            step();
        end
        checks++;
        if ({e_ser, e_done} !== 2'b01) begin
            errors++;
            $display("FAIL rstvalid parity got %b want 01", {e_ser, e_done});
        end
        step();
    endtask

    task automatic test_width1();
        w_valid = 1'b1;
        w_data  = 1'b1;
        step();
        checks++;
        if ({w_ser, w_ser_valid, w_is_par, w_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL w1 data_bit got %b want 1100", {w_ser, w_ser_valid, w_is_par, w_ready});
        end
        step();
        checks++;
        if ({w_ser, w_is_par, w_done, w_busy} !== 4'b1111) begin
            errors++;
            $display("FAIL w1 parity got %b want 1111", {w_ser, w_is_par, w_done, w_busy});
        end
        step();
        checks++;
        if ({w_ready, w_ser_valid} !== 2'b10) begin
            errors++;
            $display("FAIL w1 idle got %b want 10", {w_ready, w_ser_valid});
        end
        step();
        w_valid = 1'b0;
        checks++;
        if ({w_ser, w_ser_valid, w_is_par} !== 3'b110) begin
            errors++;
            $display("FAIL w1 period3_restart got %b want 110", {w_ser, w_ser_valid, w_is_par});
        end
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_even_frames();
        test_odd_zero();
        test_back_to_back();
        test_reset_mid_frame();
        test_reset_and_valid();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
